// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath widths and register-number type
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - in-flight destination-register scoreboard with writeback-masked busy outputs
module reg_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_reg_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_reg_i,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic              busy1_o,
  output logic              busy2_o
);
  import mips_pkg::*;

  localparam int                NREGS     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Set is applied after clear so a same-cycle issue to the register being
  // written back leaves it busy for the new producer.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i && (wr_reg_i != ZERO_ADDR)) begin
      busy_d[wr_reg_i] = 1'b0;
    end
    if (issue_valid_i && (issue_reg_i != ZERO_ADDR)) begin
      busy_d[issue_reg_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1_o = busy_q[ra1_i] && !(wr_en_i && (wr_reg_i == ra1_i));
  assign busy2_o = busy_q[ra2_i] && !(wr_en_i && (wr_reg_i == ra2_i));

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 MIPS register file, $0 hardwired, write-first bypass, busy scoreboard
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              busy1,
  output logic              busy2
);
  import mips_pkg::*;

  localparam int                NREGS     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_hit;

  assign wr_hit = RegWrite && (WriteReg != ZERO_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit) begin
      regs_q[WriteReg] <= WriteData;
    end
  end

  // Bypass stays live during reset; only storage and scoreboard are held.
  always_comb begin
    if (ra1 == ZERO_ADDR) begin
      rd1 = '0;
    end else if (RegWrite && (WriteReg == ra1)) begin
      rd1 = WriteData;
    end else begin
      rd1 = regs_q[ra1];
    end
  end

  always_comb begin
    if (ra2 == ZERO_ADDR) begin
      rd2 = '0;
    end else if (RegWrite && (WriteReg == ra2)) begin
      rd2 = WriteData;
    end else begin
      rd2 = regs_q[ra2];
    end
  end

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_reg_i   (issue_reg),
    .wr_en_i       (RegWrite),
    .wr_reg_i      (WriteReg),
    .ra1_i         (ra1),
    .ra2_i         (ra2),
    .busy1_o       (busy1),
    .busy2_o       (busy2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - vector-table and scoreboard-queue bench for reg_file
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteReg = '0;
  logic [31:0] WriteData = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic        busy1;
  logic        busy2;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[18];

  reg_file dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .RegWrite    (RegWrite),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .busy1       (busy1),
    .busy2       (busy2)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic we, logic [4:0] wr, logic [31:0] wd,
                              logic iv, logic [4:0] ir,
                              logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] e1, logic [31:0] e2,
                              logic eb1, logic eb2);
    vec_t v;
    v.we = we; v.wr = wr; v.wd = wd; v.iv = iv; v.ir = ir;
    v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    RegWrite    = v.we;
    WriteReg    = v.wr;
    WriteData   = v.wd;
    issue_valid = v.iv;
    issue_reg   = v.ir;
    ra1         = v.a1;
    ra2         = v.a2;
    exp_q.push_back(v);
  endtask

  task automatic check_pop(string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      cmp({tag, ".rd1"},   rd1,            e.e1);
      cmp({tag, ".rd2"},   rd2,            e.e2);
      cmp({tag, ".busy1"}, {31'd0, busy1}, {31'd0, e.eb1});
      cmp({tag, ".busy2"}, {31'd0, busy2}, {31'd0, e.eb2});
    end
  endtask

  task automatic step(vec_t v, string tag);
    @(posedge clk);
    #1;
    apply(v);
    @(negedge clk);
    check_pop(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            we wr  wd            iv ir  a1  a2  e1            e2            b1 b2
    tbl[0]  = mk(1, 8,  32'hDEADBEEF, 0, 0,  8,  0,  32'hDEADBEEF, 32'h0,        0, 0);
    tbl[1]  = mk(0, 0,  32'h0,        0, 0,  8,  8,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tbl[2]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,  0,  0,  32'h0,        32'h0,        0, 0);
    tbl[3]  = mk(0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        32'h0,        0, 0);
    tbl[4]  = mk(0, 0,  32'h0,        1, 9,  8,  9,  32'hDEADBEEF, 32'h0,        0, 0);
    tbl[5]  = mk(0, 0,  32'h0,        0, 0,  9,  9,  32'h0,        32'h0,        1, 1);
    tbl[6]  = mk(1, 9,  32'h5,        0, 0,  9,  9,  32'h5,        32'h5,        0, 0);
    tbl[7]  = mk(0, 0,  32'h0,        0, 0,  9,  9,  32'h5,        32'h5,        0, 0);
    tbl[8]  = mk(1, 10, 32'hAA,       1, 10, 10, 10, 32'hAA,       32'hAA,       0, 0);
    tbl[9]  = mk(0, 0,  32'h0,        1, 11, 10, 10, 32'hAA,       32'hAA,       1, 1);
    tbl[10] = mk(1, 11, 32'h11,       1, 12, 11, 12, 32'h11,       32'h0,        0, 0);
    tbl[11] = mk(0, 0,  32'h0,        0, 0,  11, 12, 32'h11,       32'h0,        0, 1);
    tbl[12] = mk(0, 0,  32'h0,        1, 12, 10, 12, 32'hAA,       32'h0,        1, 1);
    tbl[13] = mk(1, 12, 32'h1234,     0, 0,  12, 12, 32'h1234,     32'h1234,     0, 0);
    tbl[14] = mk(0, 0,  32'h0,        0, 0,  12, 10, 32'h1234,     32'hAA,       0, 1);
    tbl[15] = mk(1, 10, 32'hBB,       0, 0,  10, 8,  32'hBB,       32'hDEADBEEF, 0, 0);
    tbl[16] = mk(0, 0,  32'h0,        1, 0,  0,  10, 32'h0,        32'hBB,       0, 0);
    tbl[17] = mk(0, 0,  32'h0,        0, 0,  0,  31, 32'h0,        32'h0,        0, 0);

    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      step(mk(0, 0, 0, 0, 0, 5'(a), 5'(31 - a), 0, 0, 0, 0), $sformatf("reset_sweep[%0d]", a));
    end

    for (int i = 0; i < 18; i++) begin
      step(tbl[i], $sformatf("vec[%0d]", i));
    end

    step(mk(1, 3, 32'h7, 1, 4, 3, 4, 32'h7, 32'h0, 0, 0), "pre_rst.wr3");
    step(mk(0, 0, 32'h0, 0, 0, 3, 4, 32'h7, 32'h0, 0, 1), "pre_rst.hold");

    #1;
    rst_n = 1'b0;
    #1;
    apply(mk(0, 0, 32'h0, 0, 0, 3, 4, 32'h0, 32'h0, 0, 0));
    #1;
    check_pop("async_rst");

    apply(mk(1, 3, 32'h99, 1, 5, 3, 5, 32'h99, 32'h0, 0, 0));
    #1;
    check_pop("rst_bypass");
    @(posedge clk);
    #1;
    apply(mk(0, 0, 32'h0, 0, 0, 3, 5, 32'h0, 32'h0, 0, 0));
    #1;
    check_pop("rst_held");
    #2;
    rst_n = 1'b1;

    step(mk(0, 0, 32'h0, 0, 0, 3, 5, 32'h0, 32'h0, 0, 0), "post_rst");
    step(mk(0, 0, 32'h0, 0, 0, 8, 4, 32'h0, 32'h0, 0, 0), "post_rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the single-cycle/multicycle MIPS datapath: the write-side consumer of the destination register number (`WriteReg`, rt or rd per `RegDst`) and the read-side source of the rs/rt operands. It holds 32 × 32-bit registers with `$0` hardwired to zero. It provides two combinational read ports with write-first bypass and one synchronous write port. An in-flight-write scoreboard tells the hazard unit which source operands are still awaiting writeback.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register-number width; register count is 2**ADDR_W
- `clk` input 1: single clock, all state updates on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `ra1` input ADDR_W: read address 1 (rs)
- `ra2` input ADDR_W: read address 2 (rt)
- `rd1` output DATA_W: read data 1, combinational
- `rd2` output DATA_W: read data 2, combinational
- `RegWrite` input 1: write enable for this cycle
- `WriteReg` input ADDR_W: destination register number (from address_select)
- `WriteData` input DATA_W: write data
- `issue_valid` input 1: an instruction writing `issue_reg` is issued this cycle
- `issue_reg` input ADDR_W: destination register of the issuing instruction
- `busy1` output 1: `ra1` has a pending, not-yet-bypassable write
- `busy2` output 1: `ra2` has a pending, not-yet-bypassable write

## Operation
- Storage: `regs[0..31]`. `regs[0]` is never written; reads of address 0 return 0 regardless of any write.
- Write: at the rising edge with `RegWrite=1` and `WriteReg!=0`, `regs[WriteReg] <= WriteData`. `RegWrite=1` with `WriteReg=0` is a legal no-op.
- Read (per port n): `rdn = 0` if `ran==0`; else `WriteData` if `RegWrite && WriteReg==ran` (write-first bypass); else `regs[ran]`.
- Scoreboard `busy_q[31:0]`, bit 0 constant 0:
  - set: `issue_valid && issue_reg!=0` sets `busy_q[issue_reg]` at the edge.
  - clear: `RegWrite && WriteReg!=0` clears `busy_q[WriteReg]` at the edge.
  - The same register set and cleared in one cycle ends set. The new producer wins.
  - Issue to an already-busy register keeps it busy. The first writeback clears it. WAW ordering is the hazard unit's responsibility.
  - Set and clear on different registers in the same cycle both take effect.
- Busy output: `busyn = busy_q[ran] && !(RegWrite && WriteReg==ran)`. A writeback in the current cycle is bypassed, so no stall is needed. Address 0 is never busy.
- Reset (`rst_n=0`, asynchronous): all `regs` are cleared to 0 and all `busy_q` bits to 0 immediately. While reset is held, `rd1`/`rd2` still bypass `WriteData` per the read rule, but writes and scoreboard updates are ignored.
- Reset mid-operation discards pending writes and busy state. Nothing is replayed after release.

## Timing
- Read latency: 0 cycles (combinational from `ra*`, `RegWrite`, `WriteReg`, `WriteData`).
- Write latency: visible through storage on the cycle after the edge. Visible through bypass in the same cycle.
- Busy latency: set is visible on the cycle after `issue_valid`. Clear is effective in the writeback cycle itself (via bypass term), and from storage on the next cycle.
- Reset-released values: `rd1=rd2=0` (absent a bypass), `busy1=busy2=0`.
- No handshakes and no back-pressure. Every write presented with `RegWrite=1` is accepted.

## Structure
- Shared package `mips_pkg`: `DATA_W`, `ADDR_W`, `REG_ZERO=5'd0`, and a `reg_addr_t` typedef. `address_select` uses the same width constant.
- One sub-module, `reg_scoreboard`: holds `busy_q` with the set/clear/priority rules and the bypass-masked busy outputs.
- The storage array and read muxes stay in `reg_file`.

## Test plan
- Reset then read all 32 addresses on both ports → every read returns 0, `busy1=busy2=0`.
- Write `WriteReg=8`, `WriteData=32'hDEADBEEF`, `ra1=8` in the same cycle → `rd1=DEADBEEF` in that cycle (bypass) and on the following cycles from storage.
- Write `WriteReg=0`, `WriteData=32'hFFFFFFFF`, `ra1=ra2=0` → `rd1=rd2=0` in the same and next cycle, and `busy` stays 0.
- `issue_valid`, `issue_reg=9`; next cycle `ra2=9` → `busy2=1`. Then `RegWrite`, `WriteReg=9`, `WriteData=5` → `busy2=0` and `rd2=5` in that same cycle, `busy_q[9]=0` after.
- Same-cycle `issue_reg=10` and writeback `WriteReg=10` → `busy` for register 10 is 1 on the next cycle. A separate write to 11 with issue to 12 → 11 clear, 12 set.
- Write `regs[3]=7` and `issue_reg=4`, then assert `rst_n=0` between edges → `rd` of 3 is 0 and busy for 4 is 0 immediately, before the next clock edge.
